// File: rtl/k_dsp_pkg.sv
// Shared definitions for the K_ALU writeback path: bank encodings and writeback FSM states.
package k_dsp_pkg;

  localparam logic [1:0] K_BANK_R = 2'd0;
  localparam logic [1:0] K_BANK_G = 2'd1;
  localparam logic [1:0] K_BANK_B = 2'd2;
  localparam int         K_BANK_W = 2;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_DRAIN = 2'b01,
    WB_STALL = 2'b10
  } wb_state_e;

  // A bank index is only meaningful when it addresses one of the populated banks.
  function automatic logic bank_valid(input logic [K_BANK_W-1:0] bank, input int banks);
    return (int'(bank) < banks);
  endfunction

endpackage

// File: rtl/k_alu_writeback_queue_if.sv
// ALU result handshake bus: the ALU is the master, the writeback queue is the slave.
interface k_alu_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic                              alu_valid;
  logic                              alu_ready;
  logic [DATA_W-1:0]                 alu_result;
  logic [ADDR_W-1:0]                 alu_addr;
  logic [k_dsp_pkg::K_BANK_W-1:0]    alu_bank;

  modport master (
    output alu_valid,
    output alu_result,
    output alu_addr,
    output alu_bank,
    input  alu_ready
  );

  modport slave (
    input  alu_valid,
    input  alu_result,
    input  alu_addr,
    input  alu_bank,
    output alu_ready
  );

endinterface

// File: rtl/k_wb_fifo.sv
// Small circular buffer holding packed writeback entries; full/empty derive from the entry count.
module k_wb_fifo #(
  parameter  int ENTRY_W = 42,
  parameter  int DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   countNext_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pushEn, popEn;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign pushEn      = push_i && !full_o && !flush_i;
  assign popEn       = pop_i && !empty_o && !flush_i;
  assign rdata_o     = mem_q[rdPtr_q];
  assign count_o     = count_q;
  assign countNext_o = count_d;

  // Pointer and count update; flush empties the queue and wins over any push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
      if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
      if (pushEn && !popEn)      count_d = count_q + 1'b1;
      else if (popEn && !pushEn) count_d = count_q - 1'b1;
    end
  end

  // Control state register; storage contents are don't-care after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/k_alu_writeback_queue.sv
// Writeback queue between K_ALU and K_wdataMemory: buffers results and drains them as write strobes.
module k_alu_writeback_queue
  import k_dsp_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int BANKS  = int'(K_BANK_B) + 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  k_alu_writeback_queue_if.slave        alu,
  input  logic                          wmem_busy,
  output logic                          wmem_write_en,
  output logic [DATA_W-1:0]             wmem_write_data,
  output logic [ADDR_W-1:0]             wmem_address,
  output logic [K_BANK_W-1:0]           wmem_bank,
  output logic [CNT_W-1:0]              occupancy,
  output logic [1:0]                    wb_state,
  output logic                          bank_err,
  output logic [15:0]                   wr_count
);

  localparam int ENTRY_W = DATA_W + ADDR_W + K_BANK_W;

  logic [ENTRY_W-1:0]  head;
  logic [DATA_W-1:0]   headData;
  logic [ADDR_W-1:0]   headAddr;
  logic [K_BANK_W-1:0] headBank;
  logic [CNT_W-1:0]    count, countNext;
  logic                full, empty;
  logic                accept, badBank, push, pop;

  logic                writeEn_q, writeEn_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [K_BANK_W-1:0] bank_q, bank_d;
  logic                bankErr_q, bankErr_d;
  logic [15:0]         wrCount_q, wrCount_d;
  wb_state_e           state_q, state_d;

  assign alu.alu_ready = !full;
  assign accept        = alu.alu_valid && alu.alu_ready;
  assign badBank       = !bank_valid(alu.alu_bank, BANKS);
  assign push          = accept && !badBank;
  assign pop           = !empty && !wmem_busy && !flush;
  assign {headData, headAddr, headBank} = head;

  k_wb_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     ({alu.alu_result, alu.alu_addr, alu.alu_bank}),
    .rdata_o     (head),
    .count_o     (count),
    .countNext_o (countNext),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Output register next values: a pop loads the head and raises the strobe for exactly one cycle.
  always_comb begin
    writeEn_d = pop;
    data_d    = data_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    wrCount_d = wrCount_q;
    bankErr_d = bankErr_q | (accept && badBank && !flush);
    if (pop) begin
      data_d    = headData;
      addr_d    = headAddr;
      bank_d    = headBank;
      wrCount_d = wrCount_q + 16'd1;
    end
  end

  // Registered memory write port, sticky error flag and commit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeEn_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      bank_q    <= '0;
      bankErr_q <= 1'b0;
      wrCount_q <= '0;
    end else begin
      writeEn_q <= writeEn_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      bankErr_q <= bankErr_d;
      wrCount_q <= wrCount_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= WB_IDLE;
    else        state_q <= state_d;
  end

  // Next state follows the post-edge fill level and the busy seen at this edge.
  always_comb begin
    state_d = WB_IDLE;
    if (flush)                state_d = WB_IDLE;
    else if (countNext == '0) state_d = WB_IDLE;
    else if (wmem_busy)       state_d = WB_STALL;
    else                      state_d = WB_DRAIN;
  end

  // FSM outputs: the state is reported directly.
  always_comb begin
    wb_state = state_q;
  end

  assign wmem_write_en   = writeEn_q;
  assign wmem_write_data = data_q;
  assign wmem_address    = addr_q;
  assign wmem_bank       = bank_q;
  assign occupancy       = count;
  assign bank_err        = bankErr_q;
  assign wr_count        = wrCount_q;

endmodule

// File: tb/tb_k_alu_writeback_queue.sv
// Self-checking bench: random and directed traffic compared against a queue-based reference model.
module tb_k_alu_writeback_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BANKS  = 3;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              wmem_busy;
  logic              wmem_write_en;
  logic [DATA_W-1:0] wmem_write_data;
  logic [ADDR_W-1:0] wmem_address;
  logic [1:0]        wmem_bank;
  logic [2:0]        occupancy;
  logic [1:0]        wb_state;
  logic              bank_err;
  logic [15:0]       wr_count;

  k_alu_writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) aluIf ();

  k_alu_writeback_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BANKS  (BANKS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .alu             (aluIf.slave),
    .wmem_busy       (wmem_busy),
    .wmem_write_en   (wmem_write_en),
    .wmem_write_data (wmem_write_data),
    .wmem_address    (wmem_address),
    .wmem_bank       (wmem_bank),
    .occupancy       (occupancy),
    .wb_state        (wb_state),
    .bank_err        (bank_err),
    .wr_count        (wr_count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  addr;
    logic [1:0]  bank;
  } entry_t;

  entry_t      modelQ[$];
  logic        expWe;
  logic [31:0] expData;
  logic [7:0]  expAddr;
  logic [1:0]  expBank;
  logic        expBankErr;
  logic [15:0] expWrCount;
  logic [1:0]  expState;
  int          checks = 0;
  int          errors = 0;
  int          maxOcc;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    expWe      = 1'b0;
    expData    = '0;
    expAddr    = '0;
    expBank    = '0;
    expBankErr = 1'b0;
    expWrCount = '0;
    expState   = ST_IDLE;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/we"},    wmem_write_en,   expWe);
    checkOutput({tag, "/data"},  wmem_write_data, expData);
    checkOutput({tag, "/addr"},  wmem_address,    expAddr);
    checkOutput({tag, "/bank"},  wmem_bank,       expBank);
    checkOutput({tag, "/occ"},   occupancy,       modelQ.size());
    checkOutput({tag, "/state"}, wb_state,        expState);
    checkOutput({tag, "/err"},   bank_err,        expBankErr);
    checkOutput({tag, "/cnt"},   wr_count,        expWrCount);
  endtask

  // One clock cycle: drive inputs, advance the model by one edge, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic valid, input logic [31:0] result,
                               input logic [7:0] addr, input logic [1:0] bank,
                               input logic busy, input logic fl);
    entry_t e;
    logic   accept;
    aluIf.alu_valid  = valid;
    aluIf.alu_result = result;
    aluIf.alu_addr   = addr;
    aluIf.alu_bank   = bank;
    wmem_busy        = busy;
    flush            = fl;
    #1;
    checkOutput({tag, "/ready"}, aluIf.alu_ready, modelQ.size() != DEPTH);
    accept = valid && (modelQ.size() != DEPTH);
    if (fl) begin
      modelQ.delete();
      expWe = 1'b0;
    end else begin
      if (modelQ.size() > 0 && !busy) begin
        e          = modelQ.pop_front();
        expWe      = 1'b1;
        expData    = e.data;
        expAddr    = e.addr;
        expBank    = e.bank;
        expWrCount = expWrCount + 16'd1;
      end else begin
        expWe = 1'b0;
      end
      if (accept) begin
        if (int'(bank) >= BANKS) expBankErr = 1'b1;
        else modelQ.push_back('{data: result, addr: addr, bank: bank});
      end
    end
    if (modelQ.size() == 0) expState = ST_IDLE;
    else if (busy)          expState = ST_STALL;
    else                    expState = ST_DRAIN;
    @(posedge clk);
    #1;
    checkAll(tag);
    if (int'(occupancy) > maxOcc) maxOcc = int'(occupancy);
  endtask

  // Main sequence: reset, directed scenarios, mid-run reset, then randomized traffic.
  initial begin
    logic [15:0] savedCount;
    reset            = 1'b0;
    flush            = 1'b0;
    wmem_busy        = 1'b0;
    aluIf.alu_valid  = 1'b1;
    aluIf.alu_result = 32'h1234_5678;
    aluIf.alu_addr   = 8'h55;
    aluIf.alu_bank   = 2'd0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    aluIf.alu_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset/ready", aluIf.alu_ready, 1'b1);

    applyStimulus("single_push", 1'b1, 32'hDEAD_BEEF, 8'h10, 2'd1, 1'b0, 1'b0);
    applyStimulus("single_wr", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("single/we",   wmem_write_en,   1'b1);
    checkOutput("single/data", wmem_write_data, 32'hDEAD_BEEF);
    checkOutput("single/addr", wmem_address,    8'h10);
    checkOutput("single/bank", wmem_bank,       2'd1);
    checkOutput("single/cnt",  wr_count,        16'd1);
    applyStimulus("single_off", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("single/we_drop", wmem_write_en, 1'b0);

    for (int i = 0; i < 5; i++)
      applyStimulus("bp_push", 1'b1, 32'hA000_0000 + i, 8'h20 + 8'(i), 2'(i % 3), 1'b1, 1'b0);
    checkOutput("bp/ready", aluIf.alu_ready, 1'b0);
    checkOutput("bp/occ",   occupancy,       3'd4);
    checkOutput("bp/state", wb_state,        ST_STALL);
    for (int i = 0; i < 5; i++)
      applyStimulus("bp_drain", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("bp/occ_end", occupancy, 3'd0);
    checkOutput("bp/cnt",     wr_count,  16'd5);

    applyStimulus("bad_bank", 1'b1, 32'hBAD0_0000, 8'h30, 2'd3, 1'b0, 1'b0);
    checkOutput("bad/occ", occupancy, 3'd0);
    applyStimulus("bad_idle", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("bad/we",  wmem_write_en, 1'b0);
    checkOutput("bad/err", bank_err,      1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus("bad_good", 1'b1, 32'hC000_0000 + i, 8'h40, 2'd2, 1'b0, 1'b0);
    applyStimulus("bad_good", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("bad/err_sticky", bank_err, 1'b1);

    savedCount = wr_count;
    for (int i = 0; i < 3; i++)
      applyStimulus("fl_fill", 1'b1, 32'hF000_0000 + i, 8'h50, 2'd0, 1'b1, 1'b0);
    applyStimulus("fl_flush", 1'b1, 32'hF0F0_F0F0, 8'h51, 2'd1, 1'b1, 1'b1);
    checkOutput("flush/occ",   occupancy,     3'd0);
    checkOutput("flush/state", wb_state,      ST_IDLE);
    checkOutput("flush/we",    wmem_write_en, 1'b0);
    checkOutput("flush/cnt",   wr_count,      savedCount);
    applyStimulus("fl_after", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("flush/no_strobe", wmem_write_en, 1'b0);

    savedCount = wr_count;
    maxOcc = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus("wrap", 1'b1, 32'h7700_0000 + i, 8'(i), 2'(i % 3), 1'b0, 1'b0);
    applyStimulus("wrap_end", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("wrap/count",   wr_count - savedCount, 16'd20);
    checkOutput("wrap/last",    wmem_write_data, 32'h7700_0013);
    checkOutput("wrap/max_occ", maxOcc <= 1, 1'b1);

    for (int i = 0; i < 3; i++)
      applyStimulus("mr_fill", 1'b1, 32'hE000_0000 + i, 8'h60, 2'd1, 1'b1, 1'b0);
    applyStimulus("mr_pop", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("mr/we_before", wmem_write_en, 1'b1);
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [1:0] rb;
      rb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      applyStimulus("rand", $urandom_range(0, 3) != 0, $urandom, 8'($urandom), rb,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0);
    end
    for (int i = 0; i < 6; i++)
      applyStimulus("rand_drain", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
